// File: rtl/irq_pending_latch4_if.sv
// Request/mask/ack bundle and grant outputs of the four-source interrupt pending latch.
// master = requesters and grant consumer; slave = the latch itself.
interface irq_pending_latch4_if;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ack;
  logic [3:0] pend_o;
  logic       irq_valid;
  logic [1:0] irq_id;

  // Grant handshake: irq_id is meaningful only while irq_valid is high and is held
  // stable until the consumer samples ack=1 on a rising clk edge; the grant then drops
  // and at least one idle cycle follows before the next irq_valid.
  modport master (
    output req,
    output mask,
    output ack,
    input  pend_o,
    input  irq_valid,
    input  irq_id
  );

  modport slave (
    input  req,
    input  mask,
    input  ack,
    output pend_o,
    output irq_valid,
    output irq_id
  );
endinterface

// File: rtl/irq_pending_latch4.sv
// Four-source interrupt pending latch with synchronizers, sticky pending bits and a
// valid/ack grant FSM (bit 3 highest priority). Define IRQ_LEVEL_EN for level-mode capture.
module irq_pending_latch4 #(
  parameter int unsigned SYNC_STAGES = 2  // legal range 2..3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  irq_pending_latch4_if.slave  bus,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [SYNC_STAGES-1:0][3:0] sync_d;
  logic [3:0]                  s_d_q;
  logic [3:0]                  sync_w;
  logic [3:0]                  set_w;
  logic [3:0]                  clr_w;
  logic [3:0]                  pending_q;
  logic [3:0]                  pending_d;
  logic [3:0]                  pend_w;
  state_e                      state_q;
  logic                        irq_valid_q;
  logic [1:0]                  irq_id_q;

  function automatic logic [1:0] prio_enc(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[3])      idx = 2'd3;
    else if (v[2]) idx = 2'd2;
    else if (v[1]) idx = 2'd1;
    return idx;
  endfunction

  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.req};
  assign sync_w = sync_q[SYNC_STAGES-1];

`ifdef IRQ_LEVEL_EN
  assign set_w = sync_w;
`else
  assign set_w = sync_w & ~s_d_q;
`endif

  // Only an acknowledged grant clears a bit; set is OR-ed in last so it wins a collision.
  always_comb begin
    clr_w = 4'b0000;
    if (state_q == ST_GRANT && bus.ack) begin
      clr_w = 4'b0001 << irq_id_q;
    end
    pending_d = (pending_q & ~clr_w) | set_w;
  end

  assign pend_w = pending_q & ~bus.mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      s_d_q     <= 4'b0000;
      pending_q <= 4'b0000;
    end else begin
      sync_q    <= sync_d;
      s_d_q     <= sync_w;
      pending_q <= pending_d;
    end
  end

  // Grant outputs are registered in the FSM and held untouched through GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_w != 4'b0000) begin
            irq_id_q    <= prio_enc(pend_w);
            irq_valid_q <= 1'b1;
            state_q     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (bus.ack) begin
            irq_valid_q <= 1'b0;
            state_q     <= ST_GAP;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          irq_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pend_o    = pend_w;
  assign bus.irq_valid = irq_valid_q;
  assign bus.irq_id    = irq_id_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_irq_pending_latch4.sv
// Directed bench for irq_pending_latch4: reset, priority/handshake, masking, hold,
// set/clear collision, async reset mid-grant and edge-vs-level capture.
module tb_irq_pending_latch4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic       clk;
  logic       rst_n;
  logic [1:0] state;
  int         checks;
  int         passes;

  irq_pending_latch4_if bus ();

  irq_pending_latch4 #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_req(input logic [3:0] v);
    bus.req = v;
    steps(2);
    bus.req = 4'b0000;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  task automatic wait_grant(output logic got, output logic [1:0] id);
    int n;
    n = 0;
    while (bus.irq_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    got = bus.irq_valid;
    id  = bus.irq_id;
  endtask

  task automatic test_reset();
    logic       got;
    logic [1:0] id;
    rst_n    = 1'b0;
    bus.req  = 4'b1111;
    bus.mask = 4'b0000;
    bus.ack  = 1'b0;
    steps(3);
    checks++; if (bus.pend_o !== 4'b0000) $display("FAIL rst_pend: got %b expected 0000", bus.pend_o); else passes++;
    checks++; if (bus.irq_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus.irq_valid); else passes++;
    checks++; if (bus.irq_id !== 2'd0) $display("FAIL rst_id: got %0d expected 0", bus.irq_id); else passes++;
    checks++; if (state !== ST_IDLE) $display("FAIL rst_state: got %0d expected 0", state); else passes++;
    rst_n = 1'b1;
    steps(2);
    checks++; if (bus.pend_o !== 4'b0000) $display("FAIL rel_pend_e2: got %b expected 0000", bus.pend_o); else passes++;
    step();
    checks++; if (bus.pend_o !== 4'b1111) $display("FAIL rel_pend_e3: got %b expected 1111", bus.pend_o); else passes++;
    checks++; if (bus.irq_valid !== 1'b0) $display("FAIL rel_valid_e3: got %b expected 0", bus.irq_valid); else passes++;
    step();
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd3)
      $display("FAIL rel_grant_e4: got valid=%b id=%0d expected valid=1 id=3", bus.irq_valid, bus.irq_id); else passes++;
    bus.req = 4'b0000;
    for (int k = 3; k >= 0; k--) begin
      wait_grant(got, id);
      checks++; if (got !== 1'b1 || id !== 2'(k))
        $display("FAIL drain_grant: got valid=%b id=%0d expected valid=1 id=%0d", got, id, k); else passes++;
      do_ack();
    end
    checks++; if (bus.pend_o !== 4'b0000) $display("FAIL drain_pend: got %b expected 0000", bus.pend_o); else passes++;
  endtask

  task automatic test_priority();
    logic       got;
    logic [1:0] id;
    steps(3);
    pulse_req(4'b0101);
    wait_grant(got, id);
    checks++; if (got !== 1'b1 || id !== 2'd2)
      $display("FAIL prio_first: got valid=%b id=%0d expected valid=1 id=2", got, id); else passes++;
    do_ack();
    checks++; if (bus.irq_valid !== 1'b0 || state !== ST_GAP)
      $display("FAIL prio_gap: got valid=%b state=%0d expected valid=0 state=2", bus.irq_valid, state); else passes++;
    checks++; if (bus.pend_o !== 4'b0001) $display("FAIL prio_clr: got %b expected 0001", bus.pend_o); else passes++;
    step();
    checks++; if (bus.irq_valid !== 1'b0 || state !== ST_IDLE)
      $display("FAIL prio_idle: got valid=%b state=%0d expected valid=0 state=0", bus.irq_valid, state); else passes++;
    step();
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd0 || state !== ST_GRANT)
      $display("FAIL prio_second: got valid=%b id=%0d state=%0d expected valid=1 id=0 state=1",
                bus.irq_valid, bus.irq_id, state); else passes++;
    do_ack();
    step();
    checks++; if (bus.pend_o !== 4'b0000 || bus.irq_valid !== 1'b0)
      $display("FAIL prio_done: got pend=%b valid=%b expected pend=0000 valid=0", bus.pend_o, bus.irq_valid); else passes++;
  endtask

  task automatic test_mask();
    logic       got;
    logic [1:0] id;
    bus.mask = 4'b1000;
    pulse_req(4'b1001);
    wait_grant(got, id);
    checks++; if (got !== 1'b1 || id !== 2'd0)
      $display("FAIL mask_grant: got valid=%b id=%0d expected valid=1 id=0", got, id); else passes++;
    checks++; if (bus.pend_o !== 4'b0001) $display("FAIL mask_pend: got %b expected 0001", bus.pend_o); else passes++;
    do_ack();
    steps(4);
    checks++; if (bus.irq_valid !== 1'b0 || bus.pend_o !== 4'b0000)
      $display("FAIL mask_block: got valid=%b pend=%b expected valid=0 pend=0000", bus.irq_valid, bus.pend_o); else passes++;
    bus.mask = 4'b0000;
    #1;
    checks++; if (bus.pend_o !== 4'b1000) $display("FAIL unmask_pend: got %b expected 1000", bus.pend_o); else passes++;
    step();
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd3)
      $display("FAIL unmask_grant: got valid=%b id=%0d expected valid=1 id=3", bus.irq_valid, bus.irq_id); else passes++;
    // masking the granted source mid-grant must not disturb the grant
    bus.mask = 4'b1000;
    steps(2);
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd3)
      $display("FAIL mask_in_grant: got valid=%b id=%0d expected valid=1 id=3", bus.irq_valid, bus.irq_id); else passes++;
    do_ack();
    bus.mask = 4'b0000;
    steps(3);
    checks++; if (bus.irq_valid !== 1'b0 || bus.pend_o !== 4'b0000)
      $display("FAIL mask_after: got valid=%b pend=%b expected valid=0 pend=0000", bus.irq_valid, bus.pend_o); else passes++;
  endtask

  task automatic test_hold();
    logic       got;
    logic [1:0] id;
    pulse_req(4'b0010);
    wait_grant(got, id);
    checks++; if (got !== 1'b1 || id !== 2'd1)
      $display("FAIL hold_grant: got valid=%b id=%0d expected valid=1 id=1", got, id); else passes++;
    bus.req = 4'b1000;
    steps(4);
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd1 || bus.pend_o !== 4'b1010)
      $display("FAIL hold_stable: got valid=%b id=%0d pend=%b expected valid=1 id=1 pend=1010",
               bus.irq_valid, bus.irq_id, bus.pend_o); else passes++;
    bus.req = 4'b0000;
    do_ack();
    wait_grant(got, id);
    checks++; if (got !== 1'b1 || id !== 2'd3)
      $display("FAIL hold_next: got valid=%b id=%0d expected valid=1 id=3", got, id); else passes++;
    do_ack();
    steps(3);
  endtask

  task automatic test_collision();
    logic       got;
    logic [1:0] id;
    pulse_req(4'b0001);
    wait_grant(got, id);
    checks++; if (got !== 1'b1 || id !== 2'd0)
      $display("FAIL coll_grant: got valid=%b id=%0d expected valid=1 id=0", got, id); else passes++;
    steps(3);
    // new edge sampled at edge k sets pending at k+2, which is the ack edge
    bus.req = 4'b0001;
    steps(2);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    bus.req = 4'b0000;
    checks++; if (bus.pend_o !== 4'b0001 || bus.irq_valid !== 1'b0 || state !== ST_GAP)
      $display("FAIL coll_setwins: got pend=%b valid=%b state=%0d expected pend=0001 valid=0 state=2",
               bus.pend_o, bus.irq_valid, state); else passes++;
    steps(2);
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd0)
      $display("FAIL coll_regrant: got valid=%b id=%0d expected valid=1 id=0", bus.irq_valid, bus.irq_id); else passes++;
    do_ack();
    steps(3);
    checks++; if (bus.pend_o !== 4'b0000 || bus.irq_valid !== 1'b0)
      $display("FAIL coll_done: got pend=%b valid=%b expected pend=0000 valid=0", bus.pend_o, bus.irq_valid); else passes++;
  endtask

  task automatic test_reset_mid();
    logic       got;
    logic [1:0] id;
    pulse_req(4'b0100);
    wait_grant(got, id);
    checks++; if (got !== 1'b1 || id !== 2'd2)
      $display("FAIL mid_grant: got valid=%b id=%0d expected valid=1 id=2", got, id); else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.irq_valid !== 1'b0 || bus.pend_o !== 4'b0000 || bus.irq_id !== 2'd0 || state !== ST_IDLE)
      $display("FAIL mid_async: got valid=%b pend=%b id=%0d state=%0d expected 0 0000 0 0",
               bus.irq_valid, bus.pend_o, bus.irq_id, state); else passes++;
    step();
    rst_n = 1'b1;
    steps(5);
    checks++; if (bus.irq_valid !== 1'b0 || bus.pend_o !== 4'b0000)
      $display("FAIL mid_lost: got valid=%b pend=%b expected valid=0 pend=0000", bus.irq_valid, bus.pend_o); else passes++;
  endtask

`ifdef IRQ_LEVEL_EN
  task automatic test_level();
    logic       got;
    logic [1:0] id;
    bus.req = 4'b0001;
    for (int r = 0; r < 3; r++) begin
      wait_grant(got, id);
      checks++; if (got !== 1'b1 || id !== 2'd0)
        $display("FAIL level_grant: got valid=%b id=%0d expected valid=1 id=0", got, id); else passes++;
      steps(2);
      checks++; if (bus.irq_valid !== 1'b1) $display("FAIL level_hold: got %b expected 1", bus.irq_valid); else passes++;
      do_ack();
      checks++; if (bus.irq_valid !== 1'b0 || state !== ST_GAP || bus.pend_o !== 4'b0001)
        $display("FAIL level_gap: got valid=%b state=%0d pend=%b expected 0 2 0001",
                 bus.irq_valid, state, bus.pend_o); else passes++;
    end
    bus.req = 4'b0000;
    wait_grant(got, id);
    do_ack();
    steps(4);
  endtask
`else
  task automatic test_edge_only();
    logic       got;
    logic [1:0] id;
    bus.req = 4'b0001;
    wait_grant(got, id);
    checks++; if (got !== 1'b1 || id !== 2'd0)
      $display("FAIL edge_grant: got valid=%b id=%0d expected valid=1 id=0", got, id); else passes++;
    do_ack();
    steps(5);
    checks++; if (bus.irq_valid !== 1'b0 || bus.pend_o !== 4'b0000)
      $display("FAIL edge_noregrant: got valid=%b pend=%b expected valid=0 pend=0000",
               bus.irq_valid, bus.pend_o); else passes++;
    bus.req = 4'b0000;
    steps(3);
  endtask
`endif

  // sequence + final report
  initial begin
    checks   = 0;
    passes   = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b1111;
    bus.mask = 4'b0000;
    bus.ack  = 1'b0;
    test_reset();
    test_priority();
    test_mask();
    test_hold();
    test_collision();
`ifdef IRQ_LEVEL_EN
    test_level();
`else
    test_edge_only();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
